// File: rtl/data_selector_arbiter.sv
// data_selector_arbiter
//   Two-port round-robin arbiter/sequencer in front of one 4x8 data_selector.
//   Requesters A and B issue STORE / FETCH / DIRECT; the block drives the
//   selector strobes for the required cycles, captures the selector output
//   and returns it to the owner with a one-cycle done pulse.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_*_i, op_*_i, adr_*_i,     request (held until gnt), op 00 none,
//   wdata_*_i                     01 STORE, 10 FETCH, 11 DIRECT
//   gnt_*_o                       one-cycle grant pulse (fields captured)
//   done_*_o, rdata_*_o           one-cycle completion pulse, result data
//   ds_data_o, ds_adr_o           selector data_i / adr_i
//   ds_read_sig_o                 selector read_sig_i (load cell)
//   ds_write_sig_o                selector write_sig_i (present cell)
//   ds_data_i                     selector data_o
module data_selector_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADR_W     = 2,
    parameter int FETCH_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_a_i,
    input  logic [1:0]        op_a_i,
    input  logic [ADR_W-1:0]  adr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    input  logic              req_b_i,
    input  logic [1:0]        op_b_i,
    input  logic [ADR_W-1:0]  adr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic              done_a_o,
    output logic              done_b_o,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] ds_data_o,
    output logic [ADR_W-1:0]  ds_adr_o,
    output logic              ds_read_sig_o,
    output logic              ds_write_sig_o,
    input  logic [DATA_W-1:0] ds_data_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_FETCH  = 2'b10;

    localparam logic [1:0] LAT = 2'(FETCH_LAT);

    logic [1:0] state;
    logic [1:0] op_q;
    logic       owner;       // 0 = A, 1 = B
    logic       last_owner;  // 0 = A, 1 = B
    logic [1:0] cnt;

    logic              valid_a, valid_b, pick_b, finish;
    logic [1:0]        sel_op;
    logic [ADR_W-1:0]  sel_adr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        valid_a   = req_a_i && (op_a_i != OP_NONE);
        valid_b   = req_b_i && (op_b_i != OP_NONE);
        // On a tie the port that did not own the previous operation wins.
        pick_b    = valid_b && (!valid_a || !last_owner);
        sel_op    = pick_b ? op_b_i    : op_a_i;
        sel_adr   = pick_b ? adr_b_i   : adr_a_i;
        sel_wdata = pick_b ? wdata_b_i : wdata_a_i;
        // Last cycle of the active phase: the next edge enters DONE.
        finish    = ((state == S_ISSUE) && ((op_q == OP_STORE) || (FETCH_LAT == 0)))
                 || ((state == S_WAIT) && (cnt == 2'd1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            op_q           <= OP_NONE;
            owner          <= 1'b0;
            last_owner     <= 1'b1;
            cnt            <= 2'd0;
            gnt_a_o        <= 1'b0;
            gnt_b_o        <= 1'b0;
            done_a_o       <= 1'b0;
            done_b_o       <= 1'b0;
            rdata_a_o      <= '0;
            rdata_b_o      <= '0;
            ds_data_o      <= '0;
            ds_adr_o       <= '0;
            ds_read_sig_o  <= 1'b0;
            ds_write_sig_o <= 1'b0;
        end else begin
            gnt_a_o  <= 1'b0;
            gnt_b_o  <= 1'b0;
            done_a_o <= 1'b0;
            done_b_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (valid_a || valid_b) begin
                        owner          <= pick_b;
                        op_q           <= sel_op;
                        gnt_a_o        <= !pick_b;
                        gnt_b_o        <= pick_b;
                        // The ds registers double as the latched adr/wdata.
                        ds_adr_o       <= sel_adr;
                        ds_data_o      <= sel_wdata;
                        ds_read_sig_o  <= sel_op[0];
                        ds_write_sig_o <= sel_op[1];
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= LAT;
                    state <= S_WAIT;
                    // A FETCH must not reload the cell while waiting.
                    if (op_q == OP_FETCH) ds_read_sig_o <= 1'b0;
                end
                S_WAIT: begin
                    cnt <= cnt - 2'd1;
                end
                S_DONE: begin
                    last_owner <= owner;
                    cnt        <= 2'd0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Entering DONE overrides the phase transitions above.
            if (finish) begin
                state          <= S_DONE;
                ds_data_o      <= '0;
                ds_adr_o       <= '0;
                ds_read_sig_o  <= 1'b0;
                ds_write_sig_o <= 1'b0;
                if (owner) done_b_o <= 1'b1;
                else       done_a_o <= 1'b1;
                if (op_q != OP_STORE) begin
                    if (owner) rdata_b_o <= ds_data_i;
                    else       rdata_a_o <= ds_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_selector_arbiter.sv
// tb_data_selector_arbiter
//   Directed bench for data_selector_arbiter with a behavioural selector
//   (4x8 cells) and a schedule-based reference model checked every cycle.
module tb_data_selector_arbiter;

    localparam int LAT = 1;
    localparam int NCYC = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [1:0] op_a, op_b, adr_a, adr_b;
    logic [7:0] wd_a, wd_b;
    logic       gnt_a_o, gnt_b_o, done_a_o, done_b_o;
    logic [7:0] rdata_a_o, rdata_b_o, ds_data_o, ds_data_i;
    logic [1:0] ds_adr_o;
    logic       ds_read_sig_o, ds_write_sig_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_selector_arbiter #(.DATA_W(8), .ADR_W(2), .FETCH_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_a_i(req_a), .op_a_i(op_a), .adr_a_i(adr_a), .wdata_a_i(wd_a),
        .req_b_i(req_b), .op_b_i(op_b), .adr_b_i(adr_b), .wdata_b_i(wd_b),
        .gnt_a_o(gnt_a_o), .gnt_b_o(gnt_b_o),
        .done_a_o(done_a_o), .done_b_o(done_b_o),
        .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
        .ds_data_o(ds_data_o), .ds_adr_o(ds_adr_o),
        .ds_read_sig_o(ds_read_sig_o), .ds_write_sig_o(ds_write_sig_o),
        .ds_data_i(ds_data_i)
    );

    // Behavioural data_selector: read_sig loads a cell, write_sig presents it.
    logic [7:0] sel_mem [0:3] = '{default: 8'h00};
    always @(posedge clk) if (ds_read_sig_o) sel_mem[ds_adr_o] <= ds_data_o;
    assign ds_data_i = ds_write_sig_o ? sel_mem[ds_adr_o] : 8'h00;

    // ---------------- reference model: per-cycle expected outputs --------
    typedef struct packed {
        logic       ga, gb, da, db;
        logic [7:0] dd;
        logic [1:0] adr;
        logic       rs, ws;
        logic       rst;
        logic       rda_set, rdb_set;
        logic [7:0] rda, rdb;
    } exp_t;

    exp_t       exp_q [0:NCYC-1];
    logic [7:0] mdl_mem [0:3] = '{default: 8'h00};
    int         cyc = 0;
    int         free_cyc = 0;
    logic       last_b = 1'b1;
    logic [7:0] er_a = 8'h00, er_b = 8'h00;
    bit         rec_on = 1'b0;
    int         order [$];

    initial for (int i = 0; i < NCYC; i++) exp_q[i] = '0;

    always @(negedge clk) begin
        exp_t       e;
        logic       va, vb, p;
        logic [1:0] op, ad;
        logic [7:0] wd, rd;
        if (cyc + 10 < NCYC) begin
            e = exp_q[cyc];
            if (e.rst)     begin er_a = 8'h00; er_b = 8'h00; end
            if (e.rda_set) er_a = e.rda;
            if (e.rdb_set) er_b = e.rdb;
            checks++;
            if ({gnt_a_o, gnt_b_o, done_a_o, done_b_o, ds_data_o, ds_adr_o,
                 ds_read_sig_o, ds_write_sig_o, rdata_a_o, rdata_b_o} !==
                {e.ga, e.gb, e.da, e.db, e.dd, e.adr, e.rs, e.ws, er_a, er_b}) begin
                errors++;
                $display("FAIL cycle_%0d outputs got gnt %b%b done %b%b ds %h@%0d r%b w%b rdata %h/%h expected gnt %b%b done %b%b ds %h@%0d r%b w%b rdata %h/%h",
                         cyc, gnt_a_o, gnt_b_o, done_a_o, done_b_o, ds_data_o, ds_adr_o,
                         ds_read_sig_o, ds_write_sig_o, rdata_a_o, rdata_b_o,
                         e.ga, e.gb, e.da, e.db, e.dd, e.adr, e.rs, e.ws, er_a, er_b);
            end
            if (rec_on && gnt_a_o) order.push_back(0);
            if (rec_on && gnt_b_o) order.push_back(1);

            // Decide what the coming edge does.
            if (rst) begin
                for (int j = cyc + 1; j <= cyc + 8; j++) exp_q[j] = '0;
                exp_q[cyc + 1].rst = 1'b1;
                free_cyc = cyc + 1;
                last_b   = 1'b1;
            end else if (cyc >= free_cyc) begin
                va = req_a && (op_a != 2'b00);
                vb = req_b && (op_b != 2'b00);
                if (va || vb) begin
                    p  = vb && (!va || !last_b);
                    op = p ? op_b : op_a;
                    ad = p ? adr_b : adr_a;
                    wd = p ? wd_b : wd_a;
                    last_b = p;
                    exp_q[cyc + 1].ga  = !p;
                    exp_q[cyc + 1].gb  = p;
                    exp_q[cyc + 1].dd  = wd;
                    exp_q[cyc + 1].adr = ad;
                    exp_q[cyc + 1].rs  = op[0];
                    exp_q[cyc + 1].ws  = op[1];
                    if (op == 2'b01) begin
                        mdl_mem[ad] = wd;
                        exp_q[cyc + 2].da = !p;
                        exp_q[cyc + 2].db = p;
                        free_cyc = cyc + 3;
                    end else begin
                        rd = (op == 2'b11) ? wd : mdl_mem[ad];
                        if (op == 2'b11) mdl_mem[ad] = wd;
                        for (int w = 1; w <= LAT; w++) begin
                            exp_q[cyc + 1 + w].dd  = wd;
                            exp_q[cyc + 1 + w].adr = ad;
                            exp_q[cyc + 1 + w].rs  = (op == 2'b10) ? 1'b0 : op[0];
                            exp_q[cyc + 1 + w].ws  = op[1];
                        end
                        exp_q[cyc + 2 + LAT].da      = !p;
                        exp_q[cyc + 2 + LAT].db      = p;
                        exp_q[cyc + 2 + LAT].rda_set = !p;
                        exp_q[cyc + 2 + LAT].rdb_set = p;
                        exp_q[cyc + 2 + LAT].rda     = rd;
                        exp_q[cyc + 2 + LAT].rdb     = rd;
                        free_cyc = cyc + 3 + LAT;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, expv);
        end
    endtask

    // Drive one request on a port and hold it until granted.
    task automatic do_req(input bit p, input logic [1:0] op, input logic [1:0] ad,
                          input logic [7:0] d, output int n);
        logic got;
        if (p) begin req_b = 1'b1; op_b = op; adr_b = ad; wd_b = d; end
        else   begin req_a = 1'b1; op_a = op; adr_a = ad; wd_a = d; end
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = p ? gnt_b_o : gnt_a_o;
        end
        chk(p ? "gnt_b_arrives" : "gnt_a_arrives", {31'd0, got}, 32'd1);
        if (p) begin req_b = 1'b0; op_b = 2'b00; end
        else   begin req_a = 1'b0; op_a = 2'b00; end
    endtask

    task automatic wait_done(input bit p);
        int n = 0;
        while (!(p ? done_b_o : done_a_o) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(p ? "done_b_arrives" : "done_a_arrives", {31'd0, (p ? done_b_o : done_a_o)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus -----------------------------------
    initial begin
        int n;
        rst = 1'b1;
        req_a = 1'b0; op_a = 2'b00; adr_a = 2'd0; wd_a = 8'h00;
        req_b = 1'b0; op_b = 2'b00; adr_b = 2'd0; wd_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {gnt_a_o, gnt_b_o, done_a_o, done_b_o, ds_data_o, ds_adr_o,
                              ds_read_sig_o, ds_write_sig_o, rdata_a_o, rdata_b_o}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // STORE A adr0 64, adr1 32
        do_req(0, 2'b01, 2'd0, 8'd64, n);
        chk("store0_issue", {ds_read_sig_o, ds_write_sig_o, ds_adr_o, ds_data_o}, {2'b10, 2'd0, 8'd64});
        @(posedge clk); #1;
        chk("store0_done", {31'd0, done_a_o}, 32'd1);
        do_req(0, 2'b01, 2'd1, 8'd32, n);
        chk("store1_issue", {ds_read_sig_o, ds_write_sig_o, ds_adr_o, ds_data_o}, {2'b10, 2'd1, 8'd32});
        @(posedge clk); #1;
        chk("store1_done", {31'd0, done_a_o}, 32'd1);
        chk("cells_0_1", {sel_mem[0], sel_mem[1]}, {8'd64, 8'd32});

        // DIRECT A adr2 123
        repeat (2) @(posedge clk); #1;
        do_req(0, 2'b11, 2'd2, 8'd123, n);
        chk("direct_strobes", {ds_read_sig_o, ds_write_sig_o}, 2'b11);
        wait_done(0);
        chk("direct_rdata", rdata_a_o, 8'd123);

        // FETCH B adr1
        do_req(1, 2'b10, 2'd1, 8'h00, n);
        chk("fetch_issue", {ds_read_sig_o, ds_write_sig_o}, 2'b01);
        @(posedge clk); #1;
        chk("fetch_wait", {ds_read_sig_o, ds_write_sig_o}, 2'b01);
        @(posedge clk); #1;
        chk("fetch_done_rdata", {done_b_o, rdata_b_o}, {1'b1, 8'd32});

        // Contention: both ports request continuously
        repeat (3) @(posedge clk); #1;
        rec_on = 1'b1;
        fork
            begin int na; repeat (3) do_req(0, 2'b10, 2'd0, 8'h00, na); end
            begin int nb; repeat (3) do_req(1, 2'b10, 2'd1, 8'h00, nb); end
        join
        repeat (6) @(posedge clk); #1;
        rec_on = 1'b0;
        chk("contention_count", order.size(), 6);
        if (order.size() >= 4)
            chk("contention_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
        chk("contention_rdata", {rdata_a_o, rdata_b_o}, {8'd64, 8'd32});

        // Reset during WAIT of a FETCH, request held throughout
        req_b = 1'b1; op_b = 2'b10; adr_b = 2'd0; wd_b = 8'h00;
        n = 0;
        while (!gnt_b_o && n < 40) begin @(posedge clk); #1; n++; end
        chk("rst_case_first_gnt", {31'd0, gnt_b_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_case_outputs", {gnt_a_o, gnt_b_o, done_a_o, done_b_o, ds_read_sig_o,
                                 ds_write_sig_o, rdata_a_o, rdata_b_o}, 22'd0);
        rst = 1'b0;
        n = 0;
        while (!gnt_b_o && n < 40) begin @(posedge clk); #1; n++; end
        chk("rst_case_regrant", {31'd0, gnt_b_o}, 32'd1);
        req_b = 1'b0; op_b = 2'b00;
        wait_done(1);
        chk("rst_case_rdata", rdata_b_o, 8'd64);

        // op 00 on A is ignored while B is served at once
        repeat (3) @(posedge clk); #1;
        req_a = 1'b1; op_a = 2'b00; adr_a = 2'd3; wd_a = 8'hFF;
        do_req(1, 2'b01, 2'd3, 8'h5A, n);
        chk("op00_b_latency", n, 1);
        chk("op00_no_gnt_a", {31'd0, gnt_a_o}, 32'd0);
        repeat (4) @(posedge clk); #1;
        req_a = 1'b0;
        chk("op00_cell3", sel_mem[3], 8'h5A);

        repeat (4) @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_selector_arbiter.md
# data_selector_arbiter

Two-port arbiter and sequencer for the 4×8-bit `data_selector` storage block. It accepts STORE, FETCH and DIRECT requests from two independent requesters (A and B) and grants them round-robin. It drives the selector's `data_i`/`adr_i`/`read_sig_i`/`write_sig_i` strobes for exactly the required cycles, captures the selector's `data_o` and returns it to the granted requester with a one-cycle done pulse. It sits directly in front of one `data_selector` instance; it is the only agent allowed to drive that instance's inputs.

## Interface

Parameters:
- `DATA_W`, default 8: data width; must match the selector.
- `ADR_W`, default 2: cell address width; must match the selector.
- `FETCH_LAT`, default 1: cycles between the end of ISSUE and capture of `ds_data_i` for FETCH/DIRECT. Legal range 0..3.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_a_i` / `req_b_i` in 1: request. Hold high, with op/adr/wdata stable, until the matching `gnt_*_o`.
- `op_a_i` / `op_b_i` in 2: operation. 00 = none (request ignored), 01 = STORE, 10 = FETCH, 11 = DIRECT.
- `adr_a_i` / `adr_b_i` in `ADR_W`: target cell.
- `wdata_a_i` / `wdata_b_i` in `DATA_W`: store/direct data.
- `gnt_a_o` / `gnt_b_o` out 1: one-cycle pulse; request fields captured; requester may change inputs from the next cycle.
- `done_a_o` / `done_b_o` out 1: one-cycle completion pulse.
- `rdata_a_o` / `rdata_b_o` out `DATA_W`: result. Valid while the matching `done` is high; holds its value until the next done for that port.
- `ds_data_o` out `DATA_W`: drives selector `data_i`.
- `ds_adr_o` out `ADR_W`: drives selector `adr_i`.
- `ds_read_sig_o` out 1: drives selector `read_sig_i` (load input into cell).
- `ds_write_sig_o` out 1: drives selector `write_sig_i` (present cell on output).
- `ds_data_i` in `DATA_W`: selector `data_o`.

## Operation

- A request is valid when `req_*_i`=1 and `op_*_i`≠00.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE**: all ds outputs are 0. On any valid request, arbitrate, latch op/adr/wdata and the owner, assert the owner's `gnt`, and go to ISSUE.
- **Arbitration**: round-robin on `last_owner`.
  - Only one port valid: that port wins.
  - Both valid: the port that is not `last_owner` wins.
  - `last_owner` resets to B, so A wins the first tie.
- **ISSUE** (1 cycle):
  - `ds_adr_o` = latched address; `ds_data_o` = latched wdata.
  - `ds_read_sig_o` = op[0]; `ds_write_sig_o` = op[1].
  - STORE → DONE. FETCH/DIRECT → WAIT, or → DONE if `FETCH_LAT`=0.
- **WAIT**: ds outputs held at their ISSUE values, except `ds_read_sig_o`, which is forced to 0 for FETCH. A down-counter loaded with `FETCH_LAT` decrements each cycle; at 1 → DONE.
- **Capture**: on the edge entering DONE from WAIT (or from ISSUE when `FETCH_LAT`=0), `ds_data_i` is captured into the owner's `rdata`. STORE captures nothing; that port's `rdata` is unchanged.
- **DONE** (1 cycle): owner's `done` = 1; ds outputs = 0; `last_owner` ← owner; → IDLE.
- Requests arriving while busy are not lost. They wait, held by the requester, and are arbitrated in the next IDLE.
- Requests during DONE are not arbitrated until IDLE (one idle cycle between operations).

## Timing

- Reset values: state IDLE; all `gnt`, `done`, `rdata`, `ds_*` outputs 0; `last_owner` = B; counter 0.
- Valid request sampled at edge k: `gnt` and ISSUE strobes are high during cycle k..k+1.
- STORE: cell written at edge k+1; `done` high during k+1..k+2. Next grant is possible at edge k+3 (3-cycle throughput).
- FETCH/DIRECT: capture at edge k+1+`FETCH_LAT`; `done` high the following cycle. With `FETCH_LAT`=1: capture at k+2, done during k+2..k+3.
- `gnt` and `done` are never high on both ports in the same cycle.
- At most one operation is outstanding.
- `rst_i` high at any edge, including mid-ISSUE or mid-WAIT:
  - The operation is aborted; no `done` is issued.
  - All outputs return to reset values in the next cycle.
  - A cell write whose ISSUE coincided with the reset edge is not guaranteed.
  - Requesters holding `req` after reset are re-arbitrated normally.
- Request fields changing after `gnt` have no effect on the operation in flight.

## Test plan

- **Reset and STORE**: `rst_i` 2 cycles → all outputs 0. A STORE adr 0 data 64, then adr 1 data 32 → `ds_read_sig_o`=1 one cycle each with matching adr/data. `done_a_o` 2 cycles after each request edge; selector cells hold 64 and 32.
- **FETCH**: B FETCH adr 1 (`FETCH_LAT`=1) → `ds_write_sig_o` high 2 cycles, `ds_read_sig_o` 0; `done_b_o` with `rdata_b_o`=32 at request+3 cycles.
- **DIRECT**: A DIRECT data 123 → both strobes high in ISSUE; `rdata_a_o`=123 with `done_a_o`.
- **Contention**: A and B request every cycle → grants alternate A, B, A, B; no cycle with both `gnt` or both `done`; each port's `rdata` matches its own fetch address.
- **Reset mid-operation**: `rst_i` asserted during WAIT of a FETCH → no `done`; outputs 0 next cycle; a held request is re-granted after `rst_i` drops.
- **Op 00**: `req_a_i`=1 with op 00 → no `gnt`, no ds activity, while a concurrent B request is served immediately.
